// File: rtl/rf16x65_queue_ctl.sv
// Two-requester, single-consumer queue controller in front of an external 16x65 register-file array.
// Scrubs the array after reset, then runs it as a circular FIFO with an even parity bit in bit 64.
module rf16x65_queue_ctl #(
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic        rclk,
    input  logic        rst_l,

    input  logic        req0_vld,
    input  logic [63:0] req0_data,
    output logic        req0_ack,
    input  logic        req1_vld,
    input  logic [63:0] req1_data,
    output logic        req1_ack,

    input  logic        deq_req,
    output logic        deq_ack,
    output logic        deq_vld,
    output logic [63:0] deq_data,
    output logic        deq_perr,

    input  logic        flush,

    output logic        rf_csn_wr,
    output logic [3:0]  rf_wr_a,
    output logic [64:0] rf_di,
    output logic        rf_csn_rd,
    output logic [3:0]  rf_rd_a,
    input  logic [64:0] rf_do,

    output logic        q_full,
    output logic        q_empty,
    output logic        q_afull,
    output logic [4:0]  q_cnt
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  scrub_q, scrub_d;
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;   // 1: requester 1 was granted last
    logic        deq_vld_q, deq_vld_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        afull_q, afull_d;

    logic        run;
    logic        scrub_wr;
    logic        push_elig;
    logic        gnt0;
    logic        gnt1;
    logic        push;
    logic        pop;
    logic [63:0] gnt_data;

    // Reset is folded into the strobes so nothing reaches the array or the
    // requesters while rst_l is low, whatever state the flops hold.
    assign run       = rst_l & (state_q == ST_RUN);
    assign scrub_wr  = rst_l & (state_q == ST_INIT);
    assign push_elig = run & ~full_q & ~flush;

    // Round-robin: a lone requester always wins; on a tie the one not granted last wins.
    assign gnt0 = push_elig & req0_vld & (~req1_vld | last_grant_q);
    assign gnt1 = push_elig & req1_vld & (~req0_vld | ~last_grant_q);
    assign push = gnt0 | gnt1;

    // Empty is sampled before this cycle's push, so a pop never bypasses write data.
    assign pop  = run & deq_req & ~empty_q & ~flush;

    assign gnt_data = gnt1 ? req1_data : req0_data;

    assign req0_ack = gnt0;
    assign req1_ack = gnt1;
    assign deq_ack  = pop;

    always_comb begin
        rf_csn_wr = 1'b1;
        rf_wr_a   = wr_ptr_q;
        rf_di     = {^gnt_data, gnt_data};
        if (scrub_wr) begin
            rf_csn_wr = 1'b0;
            rf_wr_a   = scrub_q;
            rf_di     = '0;
        end else if (push) begin
            rf_csn_wr = 1'b0;
        end
    end

    assign rf_csn_rd = ~pop;
    assign rf_rd_a   = rd_ptr_q;

    // The array returns read data one cycle after the select; parity is checked on the fly.
    assign deq_vld  = deq_vld_q & rst_l;
    assign deq_data = rf_do[63:0];
    assign deq_perr = deq_vld_q & rst_l & (^rf_do);

    assign q_full  = full_q;
    assign q_empty = empty_q;
    assign q_afull = afull_q;
    assign q_cnt   = cnt_q;

    // NOTE: every signal assigned in this block gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        scrub_d      = scrub_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        deq_vld_d    = pop;

        unique case (state_q)
            ST_INIT: begin
                scrub_d = scrub_q + 4'd1;
                if (scrub_q == 4'd15) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end else begin
                    if (push) begin
                        wr_ptr_d     = wr_ptr_q + 4'd1;
                        last_grant_d = gnt1;
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + 4'd1;
                    end
                    cnt_d = cnt_q + {4'b0, push} - {4'b0, pop};
                end
            end
            default: state_d = ST_INIT;
        endcase

        full_d  = (cnt_d == 5'd16);
        empty_d = (cnt_d == 5'd0);
        afull_d = (32'(cnt_d) >= AFULL_THRESH);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            state_q      <= ST_INIT;
            scrub_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            deq_vld_q    <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            scrub_q      <= scrub_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            deq_vld_q    <= deq_vld_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            afull_q      <= afull_d;
        end
    end

    // Structural invariants of the controller; ignored by synthesis.
    a_cnt_range: assert property (@(posedge rclk) disable iff (!rst_l) cnt_q <= 5'd16);
    a_no_rw_collide: assert property (@(posedge rclk) disable iff (!rst_l)
        (!rf_csn_wr && !rf_csn_rd) |-> (rf_wr_a != rf_rd_a));
    a_one_grant: assert property (@(posedge rclk) disable iff (!rst_l) !(gnt0 && gnt1));

endmodule
